control_unit: RTL
=================

# control_unit

Hardwired Moore/Mealy control sequencer that sits directly upstream of the single-bus datapath. It reads the instruction register and the memory ready strobe, and steps through fetch and execute T-states for a fixed instruction subset. In each T-state it drives every datapath enable, bus-select, ALU-op and memory strobe.

## Interface
- No parameters. Instruction field positions and ALU codes are package constants.
- clock  in  1  rising-edge system clock
- clear  in  1  reset, asynchronous, active-low
- ir  in  32  IR register output: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
- mem_ready  in  1  memory completes the current Read/Write this cycle
- stop  in  1  level; halt at the next instruction boundary
- PCout, Zlowout, MDRout, Cout  out  1 each  bus source selects; Cout drives sign-extended C
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  ALU B=1 select, memory read, memory write
- alu_op  out  5  ALU opcode: ADD=0, SUB=1, AND=4, OR=5
- Rin, Rout  out  16 each  one-hot general-register load/drive
- illegal  out  1  one-cycle pulse in T3 on an unsupported opcode
- halted  out  1  high in HALT

## Operation
- States: RST, T0–T7, HALT. All outputs are decoded from state and ir, except the Mealy MDRin/Write gating listed below.
- RST: all outputs 0. Goes to T0 on the first edge after clear deasserts.
- T0: PCout, MARin, IncPC, Zin, alu_op=ADD.
- T1: Zlowout, PCin, Read. MDRin = mem_ready. Holds in T1 until mem_ready. PCin is asserted only in the T1 cycle where mem_ready=1.
- T2: MDRout, IRin. If stop=1 at T2, go to HALT after T2; ir is ignored.
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, nop 11010, halt 11011.
- add/sub/and/or:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_op, Zin.
  - T5: Zlowout, Rin[Ra]. Then T0.
- addi: T3 as above. T4: Cout, ADD, Zin. T5: Zlowout, Rin[Ra]. Then T0.
- ld/st common steps:
  - T3: Rout[Rb], Yin. When Rb=0, Rout stays 0, so the bus carries 0 as the base.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, MARin.
- ld:
  - T6: Read. MDRin=mem_ready; wait in T6 until mem_ready.
  - T7: MDRout, Rin[Ra]. Then T0.
- st:
  - T6: Rout[Ra], MDRin (Read=0, so MDR loads from the bus).
  - T7: Write; wait until mem_ready. Then T0.
- nop: T2 goes directly to T0.
- halt: T2 goes to HALT.
- Any other opcode: illegal pulse in T3, then T0. This is a single cycle with no datapath enables.
- HALT: all outputs 0 except halted=1. Leaves HALT only through clear.
- Never assert two bus sources in one cycle, and never assert Rin and Rout for the same register in one cycle.

## Timing
- Latency with mem_ready tied high:
  - nop: 3 cycles.
  - ALU and addi: 6 cycles.
  - ld and st: 8 cycles.
  - Each cycle of mem_ready=0 adds exactly one cycle to T1, T6(ld) or T7(st).
- clear low at any time: state=RST and all outputs 0 immediately, without waiting for an edge. The in-flight instruction and any memory strobe are abandoned.
- stop sampled only in T2. Asserting it mid-execute finishes the current instruction, then halts after the next fetch.
- mem_ready is ignored outside T1, ld-T6 and st-T7.

## Configuration
- CU_MEM_HANDSHAKE_EN defined: wait states as described.
- Undefined: mem_ready is ignored; memory states last exactly one cycle; MDRin and PCin are unconditional in T1 and ld-T6.

## Structure
- Package cu_pkg holds:
  - state enum
  - opcode constants
  - ALU op constants
  - IR field bit positions
- Sub-module reg_select: takes a 4-bit register index plus an enable and produces a 16-bit one-hot vector. Instantiate it twice, once for Rin and once for Rout.

## Test plan
- Reset then release with mem_ready=1 and ir=0x192B0000 (add R2,R5,R6) → T0–T5 in 6 cycles. T3: Rout=0x0020, Yin. T4: Rout=0x0040, alu_op=0, Zin. T5: Rin=0x0004, Zlowout.
- mem_ready held low 3 cycles in T1 → Read held for 4 cycles; MDRin and PCin each high exactly once, in the 4th.
- ld with mem_ready low 2 cycles in T6 → 10 total cycles; Rin[Ra] only in T7.
- st R3 (Ra=3) → T6: Rout=0x0008, MDRin=1, Read=0. T7: Write=1 for one cycle.
- ir opcode 11111 → illegal=1 for exactly 1 cycle, no enables asserted, next state T0. ir opcode 11011 → halted=1 stays high until clear.
- clear pulsed low during ld-T6 → all outputs 0 asynchronously. After release: RST, then T0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants for the control sequencer: T-state encoding, opcodes,
// ALU operation codes and instruction-register field positions.
package cu_pkg;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd4;
    localparam logic [4:0] ALU_OR  = 5'd5;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_select.sv
// 4-bit register index to 16-bit one-hot select, forced to zero when disabled.
module reg_select (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);

    assign o_onehot = i_en ? (16'd1 << i_idx) : 16'd0;

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus datapath.
// Define CU_MEM_HANDSHAKE_EN to stretch memory T-states until mem_ready.
module control_unit
    import cu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        illegal,
    output logic        halted
);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  w_op;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_ldst, w_legal, w_mem_ok;
    logic        w_rin_en, w_rout_en;
    logic [3:0]  w_rout_idx;
    logic        w_unused_bits;

    assign w_op          = ir[OPC_HI:OPC_LO];
    assign w_ra          = ir[RA_HI:RA_LO];
    assign w_rb          = ir[RB_HI:RB_LO];
    assign w_rc          = ir[RC_HI:RC_LO];
    assign w_ldst        = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_legal       = is_alu(w_op) || (w_op == OP_ADDI) || w_ldst;
    // The low constant bits reach the datapath through Cout, not through this block.
    assign w_unused_bits = ^ir[14:0];

`ifdef CU_MEM_HANDSHAKE_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mr;
    assign w_mem_ok    = 1'b1;
    assign w_unused_mr = mem_ready;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   if (w_mem_ok) w_next = S_T2;
            S_T2: begin
                if (stop || (w_op == OP_HALT)) w_next = S_HALT;
                else if (w_op == OP_NOP)       w_next = S_T0;
                else                           w_next = S_T3;
            end
            S_T3:   w_next = w_legal ? S_T4 : S_T0;
            S_T4:   w_next = S_T5;
            S_T5:   w_next = w_ldst ? S_T6 : S_T0;
            S_T6:   if ((w_op == OP_ST) || w_mem_ok) w_next = S_T7;
            S_T7:   if ((w_op == OP_LD) || w_mem_ok) w_next = S_T0;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= S_RST;
        else        r_state <= w_next;
    end

    // Outputs follow the state combinationally so that clear zeroes them without an edge.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0; illegal = 1'b0; halted = 1'b0;
        alu_op     = ALU_ADD;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_idx = w_rb;
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; Read = 1'b1; PCin = w_mem_ok; MDRin = w_mem_ok; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (w_legal) begin
                    Yin       = 1'b1;
                    w_rout_en = !(w_ldst && (w_rb == 4'd0));
                end else begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_alu(w_op)) begin
                    w_rout_en  = 1'b1;
                    w_rout_idx = w_rc;
                    alu_op     = alu_code(w_op);
                end else begin
                    Cout = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_ldst) MARin = 1'b1;
                else        w_rin_en = 1'b1;
            end
            S_T6: begin
                if (w_op == OP_LD) begin
                    Read  = 1'b1;
                    MDRin = w_mem_ok;
                end else begin
                    w_rout_en  = 1'b1;
                    w_rout_idx = w_ra;
                    MDRin      = 1'b1;
                end
            end
            S_T7: begin
                if (w_op == OP_LD) begin
                    MDRout   = 1'b1;
                    w_rin_en = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    reg_select u_rin_sel (
        .i_idx    (w_ra),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    reg_select u_rout_sel (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

endmodule
